// File: rtl/mprj_io_cfg_seq.sv
// GPIO pad configuration sequencer: holds one config word per pad and
// serially shifts all of them into the pad control chain, then strobes the load.
module mprj_io_cfg_seq #(
  parameter int unsigned NPADS    = 38,
  parameter int unsigned CFG_BITS = 13,
  parameter int unsigned CLK_DIV  = 4,
  parameter logic [CFG_BITS-1:0] DEF_CFG = 13'h0403,
  localparam int unsigned ADDR_W  = (NPADS > 1) ? $clog2(NPADS) : 1
) (
  input  logic                wb_clk_i,
  input  logic                wb_rst_i,
  input  logic                cfg_we,
  input  logic [ADDR_W-1:0]   cfg_addr,
  input  logic [CFG_BITS-1:0] cfg_wdata,
  output logic [CFG_BITS-1:0] cfg_rdata,
  output logic                cfg_wr_err,
  input  logic                xfer_start,
  output logic                busy,
  output logic                done,
  output logic                serial_clock,
  output logic                serial_data,
  output logic                serial_load
);

  localparam int unsigned DIV_W = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam int unsigned BIT_W = (CFG_BITS > 1) ? $clog2(CFG_BITS) : 1;
  localparam int unsigned PAD_W = ADDR_W;

  typedef enum logic [2:0] {IDLE, SHIFT_LO, SHIFT_HI, LOAD_HI, LOAD_LO} state_t;

  state_t              state, state_n;
  logic [DIV_W-1:0]    div_cnt, div_cnt_n;
  logic [BIT_W-1:0]    bit_cnt, bit_cnt_n;
  logic [PAD_W-1:0]    pad_cnt, pad_cnt_n;
  logic [CFG_BITS-1:0] regs [NPADS];

  logic busy_n, done_n, sclk_n, sdata_n, sload_n;
  logic last_div, addr_ok, start_ok, wr_ok;

  assign last_div = (div_cnt == DIV_W'(CLK_DIV - 1));
  assign addr_ok  = (32'(cfg_addr) < NPADS);
  assign start_ok = (state == IDLE) && xfer_start;
  assign wr_ok    = cfg_we && (state == IDLE) && !xfer_start && addr_ok;

  // State and counter register
  always_ff @(posedge wb_clk_i) begin
    if (wb_rst_i) begin
      state   <= IDLE;
      div_cnt <= '0;
      bit_cnt <= '0;
      pad_cnt <= '0;
    end else begin
      state   <= state_n;
      div_cnt <= div_cnt_n;
      bit_cnt <= bit_cnt_n;
      pad_cnt <= pad_cnt_n;
    end
  end

  // Next-state and counter sequencing
  always_comb begin
    state_n   = state;
    div_cnt_n = div_cnt;
    bit_cnt_n = bit_cnt;
    pad_cnt_n = pad_cnt;
    case (state)
      IDLE: begin
        if (xfer_start) begin
          state_n   = SHIFT_LO;
          div_cnt_n = '0;
          bit_cnt_n = BIT_W'(CFG_BITS - 1);
          pad_cnt_n = PAD_W'(NPADS - 1);
        end
      end
      SHIFT_LO: begin
        div_cnt_n = last_div ? '0 : div_cnt + DIV_W'(1);
        if (last_div) state_n = SHIFT_HI;
      end
      SHIFT_HI: begin
        div_cnt_n = last_div ? '0 : div_cnt + DIV_W'(1);
        if (last_div) begin
          if (bit_cnt == '0 && pad_cnt == '0) begin
            state_n = LOAD_HI;
          end else begin
            state_n = SHIFT_LO;
            if (bit_cnt == '0) begin
              bit_cnt_n = BIT_W'(CFG_BITS - 1);
              pad_cnt_n = pad_cnt - PAD_W'(1);
            end else begin
              bit_cnt_n = bit_cnt - BIT_W'(1);
            end
          end
        end
      end
      LOAD_HI: begin
        div_cnt_n = last_div ? '0 : div_cnt + DIV_W'(1);
        if (last_div) state_n = LOAD_LO;
      end
      LOAD_LO: begin
        div_cnt_n = last_div ? '0 : div_cnt + DIV_W'(1);
        if (last_div) state_n = IDLE;
      end
      default: state_n = IDLE;
    endcase
  end

  // Output decode from the upcoming state so the outputs can be registered
  always_comb begin
    busy_n  = (state_n != IDLE);
    sclk_n  = (state_n == SHIFT_HI);
    sload_n = (state_n == LOAD_HI);
    done_n  = (state_n == LOAD_LO) && (div_cnt_n == DIV_W'(CLK_DIV - 1));
    sdata_n = 1'b0;
    if (state_n == SHIFT_LO || state_n == SHIFT_HI) sdata_n = regs[pad_cnt_n][bit_cnt_n];
  end

  always_ff @(posedge wb_clk_i) begin
    if (wb_rst_i) begin
      busy         <= 1'b0;
      done         <= 1'b0;
      serial_clock <= 1'b0;
      serial_data  <= 1'b0;
      serial_load  <= 1'b0;
      cfg_wr_err   <= 1'b0;
      cfg_rdata    <= DEF_CFG;
    end else begin
      busy         <= busy_n;
      done         <= done_n;
      serial_clock <= sclk_n;
      serial_data  <= sdata_n;
      serial_load  <= sload_n;
      cfg_wr_err   <= cfg_we && !wr_ok;
      cfg_rdata    <= addr_ok ? regs[cfg_addr] : '0;
    end
  end

  // Config register file; writes only land while idle
  always_ff @(posedge wb_clk_i) begin
    if (wb_rst_i) begin
      for (int i = 0; i < int'(NPADS); i++) regs[i] <= DEF_CFG;
    end else if (wr_ok) begin
      regs[cfg_addr] <= cfg_wdata;
    end
  end

  logic unused_start_ok;
  assign unused_start_ok = start_ok;

endmodule

// File: tb/tb_mprj_io_cfg_seq.sv
// Randomized bench for mprj_io_cfg_seq against a word-array / bit-stream model.
module tb_mprj_io_cfg_seq;

  localparam int unsigned NPADS    = 3;
  localparam int unsigned CFG_BITS = 4;
  localparam int unsigned CLK_DIV  = 2;
  localparam int NB       = NPADS * CFG_BITS;
  localparam int BUSY_CYC = (2 * NB + 2) * CLK_DIV;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       cfg_we = 1'b0;
  logic [1:0] cfg_addr = '0;
  logic [3:0] cfg_wdata = '0;
  logic [3:0] cfg_rdata;
  logic       cfg_wr_err;
  logic       xfer_start = 1'b0;
  logic       busy, done, serial_clock, serial_data, serial_load;

  int n_chk = 0;
  int n_fail = 0;
  logic [3:0] model [NPADS];

  mprj_io_cfg_seq #(.NPADS(NPADS), .CFG_BITS(CFG_BITS), .CLK_DIV(CLK_DIV), .DEF_CFG(4'h5)) dut (
    .wb_clk_i(clk), .wb_rst_i(rst), .cfg_we(cfg_we), .cfg_addr(cfg_addr),
    .cfg_wdata(cfg_wdata), .cfg_rdata(cfg_rdata), .cfg_wr_err(cfg_wr_err),
    .xfer_start(xfer_start), .busy(busy), .done(done), .serial_clock(serial_clock),
    .serial_data(serial_data), .serial_load(serial_load)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic model_reset();
    for (int i = 0; i < int'(NPADS); i++) model[i] = 4'h5;
  endtask

  function automatic logic [NB-1:0] model_stream();
    logic [NB-1:0] s;
    int k;
    s = '0;
    k = NB - 1;
    for (int p = int'(NPADS) - 1; p >= 0; p--)
      for (int b = int'(CFG_BITS) - 1; b >= 0; b--) begin
        s[k] = model[p][b];
        k--;
      end
    return s;
  endfunction

  task automatic do_write(input logic [1:0] a, input logic [3:0] d, input bit idle);
    bit exp_err;
    exp_err = !idle || (a >= NPADS);
    cfg_we = 1'b1; cfg_addr = a; cfg_wdata = d;
    tick();
    cfg_we = 1'b0;
    chk("wr_err", 32'(cfg_wr_err), 32'(exp_err));
    if (!exp_err) model[a] = d;
    tick();
    chk("wr_err_pulse", 32'(cfg_wr_err), 32'd0);
  endtask

  task automatic do_read(input logic [1:0] a);
    cfg_addr = a;
    tick();
    chk("rdata", 32'(cfg_rdata), (a < NPADS) ? 32'(model[a]) : 32'd0);
  endtask

  task automatic wait_idle();
    int n;
    n = 0;
    while (busy && n < 500) begin tick(); n++; end
    chk("idle_timeout", 32'(busy), 32'd0);
  endtask

  // Starts a transfer from idle and checks the whole stream against the model
  task automatic run_xfer(input bit hold);
    logic [NB-1:0] exp_s, got_s;
    int cyc, done_at, n_done, load_cyc, rises, hi_run, bad_hi, last_rise, first_load;
    logic prev_clk, held;
    exp_s = model_stream();
    chk("idle_busy", 32'(busy), 32'd0);
    chk("idle_sclk", 32'(serial_clock), 32'd0);
    chk("idle_sload", 32'(serial_load), 32'd0);
    xfer_start = 1'b1;
    tick();
    if (!hold) xfer_start = 1'b0;
    cyc = 0; done_at = -1; n_done = 0; load_cyc = 0; rises = 0; hi_run = 0; bad_hi = 0;
    last_rise = 0; first_load = -1; prev_clk = 1'b0; held = 1'b0; got_s = '0;
    while (busy && cyc < 400) begin
      cyc++;
      if (done) begin done_at = cyc; n_done++; end
      if (serial_load) begin
        load_cyc++;
        if (first_load < 0) first_load = cyc;
        if (serial_clock) bad_hi++;
      end
      if (serial_clock && !prev_clk) begin
        if (rises < NB) got_s[NB - 1 - rises] = serial_data;
        rises++;
        last_rise = cyc;
        held = serial_data;
      end
      if (serial_clock) begin
        hi_run++;
        if (serial_data != held) bad_hi++;
      end else begin
        if (prev_clk && hi_run != int'(CLK_DIV)) bad_hi++;
        hi_run = 0;
      end
      prev_clk = serial_clock;
      tick();
    end
    chk("busy_len", 32'(cyc), 32'(BUSY_CYC));
    chk("done_pos", 32'(done_at), 32'(BUSY_CYC));
    chk("done_cnt", 32'(n_done), 32'd1);
    chk("load_len", 32'(load_cyc), 32'(CLK_DIV));
    chk("load_after_bits", 32'(first_load > last_rise), 32'd1);
    chk("rises", 32'(rises), 32'(NB));
    chk("stream", 32'(got_s), 32'(exp_s));
    chk("sclk_shape", 32'(bad_hi), 32'd0);
  endtask

  initial begin
    int loads, rises;
    logic prev;
    model_reset();

    // Reset state
    rst = 1'b1;
    tick(); tick();
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_outs", 32'({done, serial_clock, serial_data, serial_load, cfg_wr_err}), 32'd0);
    chk("rst_rdata", 32'(cfg_rdata), 32'h5);
    rst = 1'b0;
    tick();

    // Default stream
    run_xfer(1'b0);

    // Directed pattern
    do_write(2'd2, 4'hA, 1'b1);
    do_write(2'd1, 4'h3, 1'b1);
    do_write(2'd0, 4'hC, 1'b1);
    for (int a = 0; a < 4; a++) do_read(2'(a));
    run_xfer(1'b0);

    // Writes dropped while busy and at out-of-range address
    xfer_start = 1'b1; tick(); xfer_start = 1'b0;
    tick(); tick(); tick();
    do_write(2'd1, 4'hF, 1'b0);
    do_read(2'd1);
    wait_idle();
    do_write(2'd3, 4'h9, 1'b1);
    do_read(2'd3);
    do_read(2'd1);

    // Write coinciding with an accepted start is dropped
    cfg_we = 1'b1; cfg_addr = 2'd0; cfg_wdata = 4'h0; xfer_start = 1'b1;
    tick();
    cfg_we = 1'b0; xfer_start = 1'b0;
    chk("wr_with_start_err", 32'(cfg_wr_err), 32'd1);
    chk("wr_with_start_busy", 32'(busy), 32'd1);
    wait_idle();
    do_read(2'd0);

    // Held start gives one transfer, then back-to-back restart on the idle cycle
    run_xfer(1'b1);
    run_xfer(1'b0);

    // Randomized configurations
    for (int it = 0; it < 5; it++) begin
      for (int n = 0; n < 6; n++) begin
        logic [1:0] a;
        a = 2'($urandom_range(0, 3));
        do_write(a, 4'($urandom), 1'b1);
      end
      do_read(2'($urandom_range(0, 3)));
      run_xfer(1'($urandom_range(0, 1)));
      if (xfer_start) begin
        xfer_start = 1'b0;
        tick();
        wait_idle();
      end
    end

    // Reset mid-transfer after six bits
    xfer_start = 1'b1; tick(); xfer_start = 1'b0;
    loads = 0; rises = 0; prev = 1'b0;
    for (int n = 0; n < 200 && rises < 6; n++) begin
      if (serial_load) loads++;
      if (serial_clock && !prev) rises++;
      prev = serial_clock;
      tick();
    end
    chk("abort_reached", 32'(rises), 32'd6);
    rst = 1'b1;
    tick();
    chk("abort_busy", 32'(busy), 32'd0);
    chk("abort_outs", 32'({done, serial_clock, serial_data, serial_load, cfg_wr_err}), 32'd0);
    rst = 1'b0;
    model_reset();
    for (int n = 0; n < 60; n++) begin
      if (serial_load) loads++;
      tick();
    end
    chk("abort_no_load", 32'(loads), 32'd0);
    chk("abort_idle", 32'(busy), 32'd0);
    for (int a = 0; a < 3; a++) do_read(2'(a));
    run_xfer(1'b0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL global_timeout: got timeout expected finish");
    $fatal(1);
  end

endmodule
